uart_tx_sched: RTL

- Round-robin scheduler that shares the single UART transmitter between NUM_REQ byte-stream requesters (e.g. VPU result dump, status/debug reporter, command echo).
- Each requester presents a message as a valid/ready byte stream terminated by a last flag.
- The grant is locked to one requester for a whole message, so messages never interleave on the line.
- The block drives the transmitter's data/enable inputs and sequences bytes from its busy/done outputs.

---
 rtl/uart_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 39 +++
 rtl/uart_tx_sched.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit path
// Purpose: scheduler state encoding and defaults shared with the transmitter.
// Ports: none (package).
package uart_pkg;

  localparam int DATA_W_DEFAULT      = 8;
  localparam int CLK_PER_BIT_DEFAULT = 50;

  typedef enum logic [1:0] {
    ARB       = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick relative to the last grant
// Purpose: choose the first asserted request searching upward from
//          i_last_grant+1 with wrap-around.
// Ports:
//   i_req_valid  [NUM_REQ]  request vector
//   i_last_grant [ID_W]     index granted most recently
//   o_valid                 at least one request is pending
//   o_id         [ID_W]     index of the chosen requester
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req_valid,
  input  logic [ID_W-1:0]    i_last_grant,
  output logic               o_valid,
  output logic [ID_W-1:0]    o_id
);

  int              w_idx;
  logic [ID_W-1:0] w_sel;

  // Walk from the farthest candidate to the nearest one; the last hit written
  // is the closest to last_grant+1, which is the round-robin winner.
  always_comb begin
    o_valid = 1'b0;
    o_id    = '0;
    w_idx   = 0;
    w_sel   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = (int'(i_last_grant) + k) % NUM_REQ;
      w_sel = ID_W'(w_idx);
      if (i_req_valid[w_sel]) begin
        o_valid = 1'b1;
        o_id    = w_sel;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin message scheduler in front of one UART transmitter
// Purpose: locks the transmitter to one requester per message, launches one
//          byte per frame, and revokes a grant whose owner stalls too long.
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-low reset
//   i_req_valid/i_req_data/i_req_last  per-requester byte stream
//   o_req_ready                  one-hot accept strobe (combinational)
//   o_tx_data, o_tx_en           registered byte and start pulse to transmitter
//   i_tx_busy, i_tx_done         transmitter status
//   o_grant_valid, o_grant_id    current message owner
//   o_msg_done, o_timeout_err    one-cycle completion / stall-revoke pulses
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = DATA_W_DEFAULT,
  parameter int STALL_TIMEOUT = 1023,
  parameter int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]        i_req_last,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic [DATA_W-1:0]         o_tx_data,
  output logic                      o_tx_en,
  input  logic                      i_tx_busy,
  input  logic                      i_tx_done,
  output logic                      o_grant_valid,
  output logic [ID_W-1:0]           o_grant_id,
  output logic                      o_msg_done,
  output logic                      o_timeout_err
);

  localparam int CNT_W = $clog2(STALL_TIMEOUT + 1);

  sched_state_t      r_state;
  logic [ID_W-1:0]   r_grant_id;
  logic [ID_W-1:0]   r_last_grant;
  logic              r_grant_valid;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              r_last;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_tx_en;
  logic              r_msg_done;
  logic              r_timeout_err;

  logic              w_arb_valid;
  logic [ID_W-1:0]   w_arb_id;
  logic [DATA_W-1:0] w_data_arr [NUM_REQ];
  logic              w_sel_valid;
  logic              w_launch;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .i_req_valid  (i_req_valid),
    .i_last_grant (r_last_grant),
    .o_valid      (w_arb_valid),
    .o_id         (w_arb_id)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_data_arr[i] = i_req_data[i*DATA_W +: DATA_W];
    end
  end

  assign w_sel_valid = i_req_valid[r_grant_id];
  assign w_launch    = (r_state == SEND) && w_sel_valid && !i_tx_busy;

  always_comb begin
    o_req_ready = '0;
    if (w_launch) begin
      o_req_ready[r_grant_id] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state       <= ARB;
      r_grant_id    <= '0;
      r_last_grant  <= ID_W'(NUM_REQ - 1);
      r_grant_valid <= 1'b0;
      r_stall_cnt   <= '0;
      r_last        <= 1'b0;
      r_tx_data     <= '0;
      r_tx_en       <= 1'b0;
      r_msg_done    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_tx_en       <= 1'b0;
      r_msg_done    <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        ARB: begin
          if (w_arb_valid) begin
            r_grant_id    <= w_arb_id;
            r_grant_valid <= 1'b1;
            r_stall_cnt   <= '0;
            r_state       <= SEND;
          end
        end
        SEND: begin
          if (w_launch) begin
            r_tx_data <= w_data_arr[r_grant_id];
            r_tx_en   <= 1'b1;
            r_last    <= i_req_last[r_grant_id];
            r_state   <= WAIT_DONE;
          end else if (!w_sel_valid && !i_tx_busy) begin
            // This increment brings the count to STALL_TIMEOUT: revoke.
            if (r_stall_cnt == CNT_W'(STALL_TIMEOUT - 1)) begin
              r_timeout_err <= 1'b1;
              r_grant_valid <= 1'b0;
              r_last_grant  <= r_grant_id;
              r_state       <= ARB;
            end else begin
              r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
          end
        end
        WAIT_DONE: begin
          if (i_tx_done) begin
            if (r_last) begin
              r_msg_done    <= 1'b1;
              r_grant_valid <= 1'b0;
              r_last_grant  <= r_grant_id;
              r_state       <= ARB;
            end else begin
              r_stall_cnt <= '0;
              r_state     <= SEND;
            end
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

  assign o_tx_data     = r_tx_data;
  assign o_tx_en       = r_tx_en;
  assign o_grant_valid = r_grant_valid;
  assign o_grant_id    = r_grant_id;
  assign o_msg_done    = r_msg_done;
  assign o_timeout_err = r_timeout_err;

endmodule
